// File: rtl/axil_csr_mc.sv
// axil_csr_mc: multi-channel AXI4-Lite CSR block for DMA descriptor queues.
// Each channel has staging registers, a doorbell-fed descriptor FIFO
// (first-word-fall-through), sticky done/overflow status and an IRQ enable.
// Build option: define AXIL_CSR_MC_STRB_EN to merge RW register writes per
// byte lane using wstrb; otherwise wstrb is ignored and writes are full-word.
module axil_csr_mc #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned CMD_FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [31:0]               wdata,
    input  logic [3:0]                wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [31:0]               rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [NUM_CH-1:0]         o_desc_valid,
    input  logic [NUM_CH-1:0]         i_desc_ready,
    output logic [NUM_CH*32-1:0]      o_desc_cmd,
    output logic [NUM_CH*32-1:0]      o_desc_spm_ptr,
    output logic [NUM_CH*32-1:0]      o_desc_size,
    output logic [NUM_CH*64-1:0]      o_desc_ddr_ptr,
    input  logic [NUM_CH-1:0]         i_ch_done,
    output logic                      o_irq
);

    localparam int unsigned PW = $clog2(CMD_FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] VERSION = 32'h2024_0312;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wr_state_t;
    typedef enum logic       {RDIDLE, RDDATA}         rd_state_t;

    wr_state_t r_wstate, w_wstate_nxt;
    rd_state_t r_rstate, w_rstate_nxt;

    logic [15:0]   r_awaddr;
    logic [1:0]    r_bresp;
    logic [1:0]    r_rresp;
    logic [31:0]   r_rdata;

    // Staging registers per channel: 0 CMD, 1 SPM_PTR, 2 DDR_LO, 3 DDR_HI, 4 SIZE
    logic [31:0]   r_stg  [NUM_CH][5];
    // FIFO entry layout: {CMD, SPM_PTR, DDR_HI, DDR_LO, SIZE}
    logic [159:0]  r_fifo [NUM_CH][CMD_FIFO_DEPTH];
    logic [PW-1:0] r_wptr [NUM_CH];
    logic [PW-1:0] r_rptr [NUM_CH];
    logic [CW-1:0] r_cnt  [NUM_CH];

    logic [NUM_CH-1:0] r_done;
    logic [NUM_CH-1:0] r_ovf;
    logic [NUM_CH-1:0] r_irq_en;
    logic              r_irq;

    logic w_aw_hs, w_w_hs, w_ar_hs;
    logic [31:0] w_wmask;

    logic [2:0] w_wr_ch, w_wr_off;
    logic       w_wr_in_ch, w_wr_ch_ok;
    logic       w_wr_err, w_stg_we, w_irq_en_we;
    logic [NUM_CH-1:0] w_done_clr, w_push, w_pop, w_full, w_ovf_set, w_ovf_clr;

    logic [15:0] w_ra;
    logic [2:0]  w_rd_ch, w_rd_off;
    logic        w_rd_in_ch, w_rd_ch_ok;
    logic [31:0] w_rd_data;
    logic        w_rd_err;

    logic [31:0]  w_cnt32   [NUM_CH];
    logic [31:0]  w_ch_stat [NUM_CH];
    logic [159:0] w_head    [NUM_CH];
    logic [7:0]   w_done8, w_full8, w_ne8;
    logic [31:0]  w_glb;

    logic w_unused;
    assign w_unused = &{1'b0, awaddr[AXI_ADDR_WIDTH-1:16], araddr[AXI_ADDR_WIDTH-1:16], wstrb};

    assign w_aw_hs = clk_en & ~rst & awvalid & (r_wstate == WRIDLE);
    assign w_w_hs  = clk_en & wvalid & (r_wstate == WRDATA);
    assign w_ar_hs = clk_en & ~rst & arvalid & (r_rstate == RDIDLE);

`ifdef AXIL_CSR_MC_STRB_EN
    assign w_wmask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
`else
    assign w_wmask = '1;
`endif

    // FSM state registers for the write and read channels
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= WRIDLE;
            r_rstate <= RDIDLE;
        end else if (clk_en) begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_rstate_nxt = r_rstate;
        case (r_wstate)
            WRIDLE:  if (w_aw_hs) w_wstate_nxt = WRDATA;
            WRDATA:  if (w_w_hs)  w_wstate_nxt = WRRESP;
            WRRESP:  if (bready)  w_wstate_nxt = WRIDLE;
            default: w_wstate_nxt = WRIDLE;
        endcase
        case (r_rstate)
            RDIDLE:  if (w_ar_hs) w_rstate_nxt = RDDATA;
            RDDATA:  if (rready)  w_rstate_nxt = RDIDLE;
            default: w_rstate_nxt = RDIDLE;
        endcase
    end

    // FSM outputs; address-ready is held low while reset is asserted
    always_comb begin
        awready = (r_wstate == WRIDLE) & ~rst;
        wready  = (r_wstate == WRDATA);
        bvalid  = (r_wstate == WRRESP);
        arready = (r_rstate == RDIDLE) & ~rst;
        rvalid  = (r_rstate == RDDATA);
    end

    assign bresp = r_bresp;
    assign rresp = r_rresp;
    assign rdata = r_rdata;
    assign o_irq = r_irq;

    assign w_wr_ch    = r_awaddr[7:5];
    assign w_wr_off   = r_awaddr[4:2];
    assign w_wr_in_ch = (r_awaddr[15:8] == 8'h03) && (r_awaddr[1:0] == 2'b00);
    assign w_wr_ch_ok = ({1'b0, w_wr_ch} < 4'(NUM_CH));

    // Per-channel FIFO occupancy flags and status words
    always_comb begin
        w_full  = '0;
        w_pop   = '0;
        w_done8 = '0;
        w_full8 = '0;
        w_ne8   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_full[c]    = (r_cnt[c] == CW'(CMD_FIFO_DEPTH));
            w_pop[c]     = (r_cnt[c] != '0) & i_desc_ready[c];
            w_cnt32[c]   = 32'(r_cnt[c]);
            w_ch_stat[c] = '0;
            w_ch_stat[c][3:0] = (w_cnt32[c] > 32'd15) ? 4'hF : w_cnt32[c][3:0];
            w_ch_stat[c][8]   = r_ovf[c];
            w_ch_stat[c][16]  = r_done[c];
            w_done8[c] = r_done[c];
            w_full8[c] = w_full[c];
            w_ne8[c]   = (r_cnt[c] != '0);
        end
        w_glb = {8'h00, w_ne8, w_full8, w_done8};
    end

    // Write decode: side-effect strobes and response for the W handshake
    always_comb begin
        w_wr_err    = 1'b0;
        w_stg_we    = 1'b0;
        w_irq_en_we = 1'b0;
        w_done_clr  = '0;
        w_push      = '0;
        w_ovf_set   = '0;
        w_ovf_clr   = '0;
        if (w_w_hs) begin
            if (w_wr_in_ch && w_wr_ch_ok) begin
                case (w_wr_off)
                    3'd0, 3'd1, 3'd2, 3'd3, 3'd4: w_stg_we = 1'b1;
                    3'd5: begin
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            if (w_wr_ch == 3'(c)) begin
                                if (w_full[c]) begin
                                    w_ovf_set[c] = 1'b1;
                                    w_wr_err     = 1'b1;
                                end else begin
                                    w_push[c] = 1'b1;
                                end
                            end
                        end
                    end
                    // CH_STATUS is read-only but a write clears the overflow sticky
                    3'd6: begin
                        w_wr_err = 1'b1;
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            if (w_wr_ch == 3'(c)) w_ovf_clr[c] = 1'b1;
                        end
                    end
                    default: w_wr_err = 1'b1;
                endcase
            end else begin
                case (r_awaddr)
                    16'h0204: w_done_clr  = wdata[NUM_CH-1:0];
                    16'h0208: w_irq_en_we = 1'b1;
                    default:  w_wr_err    = 1'b1;
                endcase
            end
        end
    end

    assign w_ra       = araddr[15:0];
    assign w_rd_ch    = w_ra[7:5];
    assign w_rd_off   = w_ra[4:2];
    assign w_rd_in_ch = (w_ra[15:8] == 8'h03) && (w_ra[1:0] == 2'b00);
    assign w_rd_ch_ok = ({1'b0, w_rd_ch} < 4'(NUM_CH));

    // Read decode from the live address; captured on the AR handshake
    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        if (w_rd_in_ch) begin
            if (w_rd_ch_ok) begin
                case (w_rd_off)
                    3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            for (int unsigned k = 0; k < 5; k++) begin
                                if (w_rd_ch == 3'(c) && w_rd_off == 3'(k)) w_rd_data = r_stg[c][k];
                            end
                        end
                    end
                    3'd5: w_rd_data = '0;
                    3'd6: begin
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            if (w_rd_ch == 3'(c)) w_rd_data = w_ch_stat[c];
                        end
                    end
                    default: w_rd_err = 1'b1;
                endcase
            end else begin
                w_rd_err = 1'b1;
            end
        end else begin
            case (w_ra)
                16'h0104: w_rd_data = VERSION;
                16'h0200: w_rd_data = w_glb;
                16'h0204: w_rd_data = '0;
                16'h0208: w_rd_data = 32'(r_irq_en);
                default:  w_rd_err  = 1'b1;
            endcase
        end
    end

    // Address latch, write response and read data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_awaddr <= '0;
            r_bresp  <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
        end else if (clk_en) begin
            if (w_aw_hs) r_awaddr <= awaddr[15:0];
            if (w_w_hs)  r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Staging and IRQ enable register writes with optional byte-lane merge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned k = 0; k < 5; k++) r_stg[c][k] <= '0;
            end
        end else if (clk_en) begin
            if (w_irq_en_we) begin
                r_irq_en <= (wdata[NUM_CH-1:0] & w_wmask[NUM_CH-1:0]) |
                            (r_irq_en & ~w_wmask[NUM_CH-1:0]);
            end
            if (w_stg_we) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    for (int unsigned k = 0; k < 5; k++) begin
                        if (w_wr_ch == 3'(c) && w_wr_off == 3'(k)) begin
                            r_stg[c][k] <= (wdata & w_wmask) | (r_stg[c][k] & ~w_wmask);
                        end
                    end
                end
            end
        end
    end

    // Descriptor FIFOs: doorbell pushes, DMA handshake pops
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
                r_cnt[c]  <= '0;
                for (int unsigned d = 0; d < CMD_FIFO_DEPTH; d++) r_fifo[c][d] <= '0;
            end
        end else if (clk_en) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (w_push[c]) begin
                    r_fifo[c][r_wptr[c]] <= {r_stg[c][0], r_stg[c][1], r_stg[c][3],
                                             r_stg[c][2], r_stg[c][4]};
                    r_wptr[c] <= r_wptr[c] + 1'b1;
                end
                if (w_pop[c]) r_rptr[c] <= r_rptr[c] + 1'b1;
                if (w_push[c] && !w_pop[c]) begin
                    r_cnt[c] <= r_cnt[c] + 1'b1;
                end else if (!w_push[c] && w_pop[c]) begin
                    r_cnt[c] <= r_cnt[c] - 1'b1;
                end
            end
        end
    end

    // Done/overflow stickies (set wins over clear) and registered interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= '0;
            r_ovf  <= '0;
            r_irq  <= 1'b0;
        end else if (clk_en) begin
            r_done <= (r_done & ~w_done_clr) | i_ch_done;
            r_ovf  <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
            r_irq  <= |(r_done & r_irq_en);
        end
    end

    // FIFO head fields presented to the DMA engines
    always_comb begin
        o_desc_valid   = '0;
        o_desc_cmd     = '0;
        o_desc_spm_ptr = '0;
        o_desc_size    = '0;
        o_desc_ddr_ptr = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_head[c]                  = r_fifo[c][r_rptr[c]];
            o_desc_valid[c]            = (r_cnt[c] != '0);
            o_desc_cmd[32*c +: 32]     = w_head[c][159:128];
            o_desc_spm_ptr[32*c +: 32] = w_head[c][127:96];
            o_desc_ddr_ptr[64*c +: 64] = w_head[c][95:32];
            o_desc_size[32*c +: 32]    = w_head[c][31:0];
        end
    end

endmodule

// File: tb/tb_axil_csr_mc.sv
// Self-checking bench for axil_csr_mc: expected responses are queued when a
// transaction is issued and compared when bvalid/rvalid appear.
module tb_axil_csr_mc;

    localparam int unsigned NCH   = 2;
    localparam int unsigned DEPTH = 4;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_en;
    logic [31:0]       awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [31:0]       araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [NCH-1:0]    o_desc_valid;
    logic [NCH-1:0]    i_desc_ready;
    logic [NCH*32-1:0] o_desc_cmd;
    logic [NCH*32-1:0] o_desc_spm_ptr;
    logic [NCH*32-1:0] o_desc_size;
    logic [NCH*64-1:0] o_desc_ddr_ptr;
    logic [NCH-1:0]    i_ch_done;
    logic              o_irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  bq[$];
    string       bt[$];
    logic [33:0] rq[$];
    string       rt[$];

    axil_csr_mc #(
        .AXI_ADDR_WIDTH(32),
        .NUM_CH(NCH),
        .CMD_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .o_desc_valid(o_desc_valid), .i_desc_ready(i_desc_ready),
        .o_desc_cmd(o_desc_cmd), .o_desc_spm_ptr(o_desc_spm_ptr),
        .o_desc_size(o_desc_size), .o_desc_ddr_ptr(o_desc_ddr_ptr),
        .i_ch_done(i_ch_done), .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write response scoreboard
    always @(negedge clk) begin
        if (bvalid === 1'b1) begin
            if (bq.size() == 0) chk("bvalid_unexpected", 64'd1, 64'd0);
            else chk(bt.pop_front(), 64'(bresp), 64'(bq.pop_front()));
        end
    end

    // Read response scoreboard
    always @(negedge clk) begin : rmon
        logic [33:0] e;
        string       t;
        if (rvalid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("rvalid_unexpected", 64'd1, 64'd0);
            end else begin
                e = rq.pop_front();
                t = rt.pop_front();
                chk({t, "_resp"}, 64'(rresp), 64'(e[33:32]));
                chk({t, "_data"}, 64'(rdata), 64'(e[31:0]));
            end
        end
    end

    task automatic axi_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er, input logic [NCH-1:0] rdy_w,
                          input logic [NCH-1:0] done_w);
        int n;
        bq.push_back(er);
        bt.push_back($sformatf("bresp_%h", a));
        @(negedge clk);
        awaddr  = {16'h0000, a};
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("awready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        i_desc_ready = rdy_w;
        i_ch_done    = done_w;
        n = 0;
        while (!wready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("wready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        wvalid       = 1'b0;
        i_desc_ready = '0;
        i_ch_done    = '0;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (bq.size() != 0 && n < 20);
        if (bq.size() != 0) begin
            chk("bvalid_timeout", 64'd0, 64'd1);
            bq.delete();
            bt.delete();
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [1:0] er);
        axi_wr(a, d, 4'hF, er, '0, '0);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        rq.push_back({er, ed});
        rt.push_back($sformatf("rd_%h", a));
        @(negedge clk);
        araddr  = {16'h0000, a};
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("arready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (rq.size() != 0 && n < 20);
        if (rq.size() != 0) begin
            chk("rvalid_timeout", 64'd0, 64'd1);
            rq.delete();
            rt.delete();
        end
    endtask

    task automatic pulse_ready(input logic [NCH-1:0] v);
        @(negedge clk);
        i_desc_ready = v;
        @(negedge clk);
        i_desc_ready = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; clk_en = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        i_desc_ready = '0; i_ch_done = '0;

        // Reset
        repeat (3) @(negedge clk);
        chk("awready_in_rst", 64'(awready), 64'd0);
        chk("arready_in_rst", 64'(arready), 64'd0);
        rst = 1'b0;
        #1;
        chk("awready_idle", 64'(awready), 64'd1);
        chk("arready_idle", 64'(arready), 64'd1);
        chk("bvalid_rst", 64'(bvalid), 64'd0);
        chk("rvalid_rst", 64'(rvalid), 64'd0);
        chk("bresp_rst", 64'(bresp), 64'd0);
        chk("rresp_rst", 64'(rresp), 64'd0);
        chk("rdata_rst", 64'(rdata), 64'd0);
        chk("desc_valid_rst", 64'(o_desc_valid), 64'd0);
        chk("irq_rst", 64'(o_irq), 64'd0);

        rd(16'h0104, 32'h2024_0312, OKAY);
        rd(16'h0200, 32'h0, OKAY);

        // Channel 1 descriptor round trip
        wr(16'h0320, 32'hA5, OKAY);
        wr(16'h0324, 32'h40, OKAY);
        wr(16'h0328, 32'h1000, OKAY);
        wr(16'h032C, 32'h1, OKAY);
        wr(16'h0330, 32'h200, OKAY);
        wr(16'h0334, 32'h0, OKAY);
        chk("ch1_valid", 64'(o_desc_valid), 64'h2);
        chk("ch1_ddr", o_desc_ddr_ptr[127:64], 64'h1_0000_1000);
        chk("ch1_cmd", 64'(o_desc_cmd[63:32]), 64'hA5);
        chk("ch1_spm", 64'(o_desc_spm_ptr[63:32]), 64'h40);
        chk("ch1_size", 64'(o_desc_size[63:32]), 64'h200);
        pulse_ready(2'b10);
        chk("ch1_popped", 64'(o_desc_valid), 64'h0);
        rd(16'h0320, 32'hA5, OKAY);

        // Push into empty FIFO with ready high on the same edge: no bypass
        axi_wr(16'h0334, 32'h0, 4'hF, OKAY, 2'b10, '0);
        chk("ch1_no_bypass", 64'(o_desc_valid), 64'h2);
        pulse_ready(2'b10);
        chk("ch1_popped2", 64'(o_desc_valid), 64'h0);

        // Channel 0 overflow
        wr(16'h0300, 32'h11, OKAY);
        for (int i = 0; i < 4; i++) wr(16'h0314, 32'h0, OKAY);
        wr(16'h0314, 32'h0, SLVERR);
        rd(16'h0318, 32'h104, OKAY);
        rd(16'h0200, 32'h0001_0100, OKAY);
        chk("ch0_head_cmd", 64'(o_desc_cmd[31:0]), 64'h11);
        wr(16'h0318, 32'h0, SLVERR);
        rd(16'h0318, 32'h004, OKAY);
        // Doorbell on a full FIFO while it pops: rejected against pre-pop count
        axi_wr(16'h0314, 32'h0, 4'hF, SLVERR, 2'b01, '0);
        rd(16'h0318, 32'h103, OKAY);
        @(negedge clk);
        i_desc_ready = 2'b01;
        repeat (4) @(negedge clk);
        i_desc_ready = '0;
        chk("ch0_drained", 64'(o_desc_valid), 64'h0);
        rd(16'h0318, 32'h100, OKAY);
        wr(16'h0318, 32'h0, SLVERR);
        rd(16'h0318, 32'h0, OKAY);

        // Interrupts and done sticky
        wr(16'h0208, 32'h1, OKAY);
        rd(16'h0208, 32'h1, OKAY);
        @(negedge clk);
        i_ch_done = 2'b01;
        @(negedge clk);
        i_ch_done = '0;
        chk("irq_latency", 64'(o_irq), 64'd0);
        @(negedge clk);
        chk("irq_set", 64'(o_irq), 64'd1);
        rd(16'h0318, 32'h1_0000, OKAY);
        axi_wr(16'h0204, 32'h1, 4'hF, OKAY, '0, 2'b01);
        rd(16'h0200, 32'h1, OKAY);
        chk("irq_set_wins", 64'(o_irq), 64'd1);
        wr(16'h0204, 32'h1, OKAY);
        rd(16'h0200, 32'h0, OKAY);
        chk("irq_cleared", 64'(o_irq), 64'd0);
        @(negedge clk);
        i_ch_done = 2'b10;
        @(negedge clk);
        i_ch_done = '0;
        repeat (2) @(negedge clk);
        chk("irq_masked", 64'(o_irq), 64'd0);
        rd(16'h0200, 32'h2, OKAY);
        wr(16'h0204, 32'h2, OKAY);
        rd(16'h0200, 32'h0, OKAY);

        // Clock enable low freezes stickies
        @(negedge clk);
        clk_en = 1'b0;
        i_ch_done = 2'b10;
        repeat (2) @(negedge clk);
        i_ch_done = '0;
        clk_en = 1'b1;
        rd(16'h0200, 32'h0, OKAY);

        // Error and write-only accesses
        wr(16'h0340, 32'hDEAD_BEEF, SLVERR);
        rd(16'h03E0, 32'h0, SLVERR);
        wr(16'h0104, 32'h1, SLVERR);
        wr(16'h0200, 32'h1, SLVERR);
        rd(16'h020C, 32'h0, SLVERR);
        rd(16'h031C, 32'h0, SLVERR);
        rd(16'h0204, 32'h0, OKAY);
        rd(16'h0314, 32'h0, OKAY);
        rd(16'h0300, 32'h11, OKAY);
        rd(16'h0320, 32'hA5, OKAY);

        // Read and write to the same register on the same edge: old value
        fork
            wr(16'h0304, 32'h55, OKAY);
            begin
                @(negedge clk);
                rd(16'h0304, 32'h0, OKAY);
            end
        join
        rd(16'h0304, 32'h55, OKAY);

        // Byte strobes
        wr(16'h0300, 32'hFFFF_FFFF, OKAY);
        axi_wr(16'h0300, 32'h0, 4'b0010, OKAY, '0, '0);
`ifdef AXIL_CSR_MC_STRB_EN
        rd(16'h0300, 32'hFFFF_00FF, OKAY);
`else
        rd(16'h0300, 32'h0, OKAY);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
